theta_gen: RTL

Phase-angle generator feeding the `Cos_control_system` cosine stage. On each step strobe it advances a signed fixed-point rotor angle by a per-step increment and wraps it to [-π, π). It converts the result to IEEE-754 single precision and emits it with a one-cycle valid pulse. Its `theta`/`done_sig` outputs connect directly to the cosine stage's `theta`/`sta` inputs.

---
 rtl/theta_gen_pkg.sv | 31 +++
 rtl/theta_gen_if.sv | 24 ++
 rtl/theta_gen_fx2float.sv | 88 ++++++++
 rtl/theta_gen.sv | 67 ++++++
 4 files changed

// File: rtl/theta_gen_pkg.sv
// Shared constants for the phase-angle generator: Q4.28 phase format,
// wrap constants and IEEE-754 single-precision field layout.
package theta_gen_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned FRAC_W  = 28;

    localparam logic [PHASE_W-1:0] PI_FX     = 32'h3243F6A9;
    localparam logic [PHASE_W-1:0] TWO_PI_FX = 32'h6487ED52;

    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned SGL_SIGN_W = 1;
    localparam int unsigned SGL_EXP_W  = 8;
    localparam int unsigned SGL_MANT_W = 23;
    localparam int unsigned SGL_W      = SGL_SIGN_W + SGL_EXP_W + SGL_MANT_W;

    // A wrapped phase is in [-pi, pi), so its magnitude always fits in 30 bits.
    localparam int unsigned MAG_W = 30;
    localparam int unsigned POS_W = 5;

    // Priority encoder: index of the most significant set bit (0 when mag is 0).
    function automatic logic [POS_W-1:0] lead_one(input logic [MAG_W-1:0] mag);
        logic [POS_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) pos = POS_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/theta_gen_if.sv
// Bundle of the step/load controls and angle outputs of theta_gen.
interface theta_gen_if;
    import theta_gen_pkg::*;

    logic               sta;
    logic               init;
    logic [PHASE_W-1:0] theta0;
    logic [PHASE_W-1:0] omega_dt;
    logic [PHASE_W-1:0] theta_fx;
    logic [SGL_W-1:0]   theta;
    logic               done_sig;
    logic               busy;

    modport master (
        output sta, init, theta0, omega_dt,
        input  theta_fx, theta, done_sig, busy
    );

    modport slave (
        input  sta, init, theta0, omega_dt,
        output theta_fx, theta, done_sig, busy
    );

endinterface

// File: rtl/theta_gen_fx2float.sv
// Three-stage Q4.28 to IEEE-754 single converter (truncating), valid in/out.
module fx2float
    import theta_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [PHASE_W-1:0] i_phase,
    output logic               o_valid,
    output logic [SGL_W-1:0]   o_theta,
    output logic               o_busy
);

    logic [PHASE_W-1:0]    w_abs;
    logic [MAG_W-1:0]      w_norm;

    logic                  r_v2, r_sign2, r_zero2;
    logic [MAG_W-1:0]      r_mag2;
    logic [POS_W-1:0]      r_pos2;

    logic                  r_v3, r_sign3, r_zero3;
    logic [SGL_EXP_W-1:0]  r_exp3;
    logic [SGL_MANT_W-1:0] r_mant3;

    logic                  r_v4;
    logic [SGL_W-1:0]      r_theta4;

    assign w_abs = i_phase[PHASE_W-1] ? (~i_phase + 32'd1) : i_phase;

    // Leading one moved to the top bit; bits below it become the mantissa.
    assign w_norm = r_mag2 << (POS_W'(MAG_W - 1) - r_pos2);

    // Stage 2: sign, magnitude, leading-one position and zero flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_zero2 <= 1'b0;
            r_mag2  <= '0;
            r_pos2  <= '0;
        end else begin
            r_v2 <= i_valid;
            if (i_valid) begin
                r_sign2 <= i_phase[PHASE_W-1];
                r_mag2  <= w_abs[MAG_W-1:0];
                r_pos2  <= lead_one(w_abs[MAG_W-1:0]);
                r_zero2 <= (w_abs[MAG_W-1:0] == '0);
            end
        end
    end

    // Stage 3: biased exponent and left-aligned, truncated mantissa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v3    <= 1'b0;
            r_sign3 <= 1'b0;
            r_zero3 <= 1'b0;
            r_exp3  <= '0;
            r_mant3 <= '0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_sign3 <= r_sign2;
                r_zero3 <= r_zero2;
                r_exp3  <= SGL_EXP_W'(EXP_BIAS - FRAC_W + 32'(r_pos2));
                r_mant3 <= w_norm[MAG_W-2 -: SGL_MANT_W];
            end
        end
    end

    // Stage 4: pack; zero is always +0. Output holds between valid samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v4     <= 1'b0;
            r_theta4 <= '0;
        end else begin
            r_v4 <= r_v3;
            if (r_v3) begin
                r_theta4 <= r_zero3 ? '0 : {r_sign3, r_exp3, r_mant3};
            end
        end
    end

    assign o_valid = r_v4;
    assign o_theta = r_theta4;
    assign o_busy  = r_v2 | r_v3;

endmodule

// File: rtl/theta_gen.sv
// Rotor phase accumulator with [-pi, pi) wrap, feeding a float converter.
module theta_gen
    import theta_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    theta_gen_if.slave  bus
);

    localparam logic signed [PHASE_W+1:0] PI_EXT     = $signed({2'b00, PI_FX});
    localparam logic signed [PHASE_W+1:0] NEG_PI_EXT = -PI_EXT;

    logic                      r_v1;
    logic [PHASE_W-1:0]        r_phase;
    logic signed [PHASE_W+1:0] w_sum;
    logic [PHASE_W-1:0]        w_phase_nxt;
    logic                      w_v1_nxt;
    logic                      w_conv_busy;

    // Two guard bits so the sum cannot overflow before the wrap compare.
    assign w_sum = $signed({{2{r_phase[PHASE_W-1]}}, r_phase})
                 + $signed({{2{bus.omega_dt[PHASE_W-1]}}, bus.omega_dt});

    // Next phase: init load has priority over a step; wrap into [-pi, pi).
    always_comb begin
        w_phase_nxt = r_phase;
        w_v1_nxt    = 1'b0;
        if (bus.init) begin
            w_phase_nxt = bus.theta0;
            w_v1_nxt    = 1'b1;
        end else if (bus.sta) begin
            w_v1_nxt = 1'b1;
            if (w_sum >= PI_EXT) begin
                w_phase_nxt = w_sum[PHASE_W-1:0] - TWO_PI_FX;
            end else if (w_sum < NEG_PI_EXT) begin
                w_phase_nxt = w_sum[PHASE_W-1:0] + TWO_PI_FX;
            end else begin
                w_phase_nxt = w_sum[PHASE_W-1:0];
            end
        end
    end

    // Stage 1 phase register and sample-valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_v1    <= w_v1_nxt;
        end
    end

    fx2float u_fx2float (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v1),
        .i_phase (r_phase),
        .o_valid (bus.done_sig),
        .o_theta (bus.theta),
        .o_busy  (w_conv_busy)
    );

    assign bus.theta_fx = r_phase;
    assign bus.busy     = r_v1 | w_conv_busy;

endmodule
